fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl_if.sv | 33 +++
 rtl/fifo_ctrl.sv | 94 +++++++++
 tb/tb_fifo_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO producer/consumer and fifo_ctrl.
// master: the side issuing push/pop/clr_err; slave: the controller.
interface fifo_ctrl_if;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic       en_write;
    logic       en_read;
    logic [4:0] ptr_in;
    logic [4:0] ptr_out;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    modport master (
        output push, pop, clr_err,
        input  en_write, en_read, ptr_in, ptr_out, rd_valid,
        input  full, empty, almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  push, pop, clr_err,
        output en_write, en_read, ptr_in, ptr_out, rd_valid,
        output full, empty, almost_full, almost_empty, count,
        output overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a 16x8 FIFO storage array; the array itself lives outside.
// Wrap-bit pointers distinguish full from empty; all flags are registered.
module fifo_ctrl #(
    parameter int unsigned AFULL_LVL  = 12,
    parameter int unsigned AEMPTY_LVL = 2
) (
    input  logic        clk,
    input  logic        reset,
    fifo_ctrl_if.slave  bus
);
    localparam logic [4:0] AFULL_L  = 5'(AFULL_LVL);
    localparam logic [4:0] AEMPTY_L = 5'(AEMPTY_LVL);

    logic [4:0] wptr;
    logic [4:0] rptr;
    logic [4:0] wptr_nxt;
    logic [4:0] rptr_nxt;
    logic [4:0] count_nxt;
    logic       wr_ok;
    logic       rd_ok;
    logic       ovf_evt;
    logic       udf_evt;
    logic       full_nxt;
    logic       empty_nxt;
    logic       afull_nxt;
    logic       aempty_nxt;

    logic [4:0] count_q;
    logic       full_q;
    logic       empty_q;
    logic       afull_q;
    logic       aempty_q;
    logic       rd_valid_q;
    logic       overflow_q;
    logic       underflow_q;

    // Handshake: push/pop are single-cycle requests; a request is taken on the
    // rising edge only when its strobe (en_write/en_read) is high that cycle.
    // A push into a full FIFO is still taken when a pop frees the slot the same
    // cycle; a pop from an empty FIFO is never taken, even alongside a push.
    always_comb begin
        wr_ok      = reset & bus.push & (~full_q | bus.pop);
        rd_ok      = reset & bus.pop & ~empty_q;
        ovf_evt    = bus.push & full_q & ~bus.pop;
        udf_evt    = bus.pop & empty_q;
        wptr_nxt   = wptr + {4'd0, wr_ok};
        rptr_nxt   = rptr + {4'd0, rd_ok};
        count_nxt  = wptr_nxt - rptr_nxt;
        empty_nxt  = (wptr_nxt == rptr_nxt);
        full_nxt   = (wptr_nxt[3:0] == rptr_nxt[3:0]) && (wptr_nxt[4] != rptr_nxt[4]);
        afull_nxt  = (count_nxt >= AFULL_L);
        aempty_nxt = (count_nxt <= AEMPTY_L);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr        <= 5'd0;
            rptr        <= 5'd0;
            count_q     <= 5'd0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr        <= wptr_nxt;
            rptr        <= rptr_nxt;
            count_q     <= count_nxt;
            full_q      <= full_nxt;
            empty_q     <= empty_nxt;
            afull_q     <= afull_nxt;
            aempty_q    <= aempty_nxt;
            rd_valid_q  <= rd_ok;
            // A fresh error in the clearing cycle wins over the clear.
            overflow_q  <= (overflow_q & ~bus.clr_err) | ovf_evt;
            underflow_q <= (underflow_q & ~bus.clr_err) | udf_evt;
        end
    end

    assign bus.en_write     = wr_ok;
    assign bus.en_read      = rd_ok;
    assign bus.ptr_in       = {1'b0, wptr[3:0]};
    assign bus.ptr_out      = {1'b0, rptr[3:0]};
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: fill, overflow, full push+pop, drain, underflow,
// pointer wrap and asynchronous reset, with hand-computed expectations.
module tb_fifo_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   passed;

    fifo_ctrl_if bus ();

    fifo_ctrl #(.AFULL_LVL(12), .AEMPTY_LVL(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total       = 0;
        passed      = 0;
        reset       = 1'b0;
        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.clr_err = 1'b0;
        cyc();
        cyc();

        // reset state, strobes blocked while reset is low
        check("rst_en_write", 32'(bus.en_write), 0);
        check("rst_en_read", 32'(bus.en_read), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_aempty", 32'(bus.almost_empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_afull", 32'(bus.almost_full), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_errs", 32'({bus.overflow, bus.underflow}), 0);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        #1 reset = 1'b1;

        // fill with 16 pushes
        bus.push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("fill_ptr_in", 32'(bus.ptr_in), i);
            check("fill_en_write", 32'(bus.en_write), 1);
            cyc();
            check("fill_count", 32'(bus.count), i + 1);
            check("fill_afull", 32'(bus.almost_full), (i + 1 >= 12) ? 1 : 0);
            check("fill_full", 32'(bus.full), (i == 15) ? 1 : 0);
        end
        check("fill_empty", 32'(bus.empty), 0);

        // push into full FIFO
        #1;
        check("ovf_en_write", 32'(bus.en_write), 0);
        cyc();
        check("ovf_flag", 32'(bus.overflow), 1);
        check("ovf_count", 32'(bus.count), 16);
        bus.push    = 1'b0;
        bus.clr_err = 1'b1;
        cyc();
        check("ovf_clr", 32'(bus.overflow), 0);
        bus.clr_err = 1'b0;

        // full with push+pop: both accepted on same address
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        #1;
        check("fpp_en_write", 32'(bus.en_write), 1);
        check("fpp_en_read", 32'(bus.en_read), 1);
        check("fpp_ptr_in", 32'(bus.ptr_in), 0);
        check("fpp_ptr_out", 32'(bus.ptr_out), 0);
        cyc();
        check("fpp_count", 32'(bus.count), 16);
        check("fpp_rd_valid", 32'(bus.rd_valid), 1);
        check("fpp_ptr_in_nxt", 32'(bus.ptr_in), 1);
        check("fpp_ptr_out_nxt", 32'(bus.ptr_out), 1);
        check("fpp_full", 32'(bus.full), 1);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        cyc();
        check("fpp_rd_valid_drop", 32'(bus.rd_valid), 0);

        // drain 16 entries
        bus.pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            check("drain_count", 32'(bus.count), 15 - i);
            check("drain_aempty", 32'(bus.almost_empty), (15 - i <= 2) ? 1 : 0);
        end
        check("drain_empty", 32'(bus.empty), 1);

        // pop while empty
        #1;
        check("udf_en_read", 32'(bus.en_read), 0);
        cyc();
        check("udf_flag", 32'(bus.underflow), 1);
        check("udf_rd_valid", 32'(bus.rd_valid), 0);
        bus.pop     = 1'b0;
        bus.clr_err = 1'b1;
        cyc();
        check("udf_clr", 32'(bus.underflow), 0);
        bus.clr_err = 1'b0;

        // empty with push+pop: push taken, pop rejected
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        #1;
        check("epp_en_write", 32'(bus.en_write), 1);
        check("epp_en_read", 32'(bus.en_read), 0);
        cyc();
        check("epp_count", 32'(bus.count), 1);
        check("epp_underflow", 32'(bus.underflow), 1);
        bus.push = 1'b0;
        cyc();
        check("epp_pop_count", 32'(bus.count), 0);

        // clear coinciding with a new underflow keeps the flag
        bus.clr_err = 1'b1;
        cyc();
        check("clr_vs_err", 32'(bus.underflow), 1);
        bus.pop = 1'b0;
        cyc();
        check("clr_only", 32'(bus.underflow), 0);
        bus.clr_err = 1'b0;
        check("wrap_start_ptr", 32'(bus.ptr_in), 2);

        // 40 alternating push/pop cycles, pointers wrap 18 -> 38 mod 32
        for (int i = 0; i < 40; i++) begin
            bus.push = (i % 2 == 0);
            bus.pop  = (i % 2 == 1);
            cyc();
            check("alt_count", 32'(bus.count), (i % 2 == 0) ? 1 : 0);
        end
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        check("alt_errs", 32'({bus.overflow, bus.underflow}), 0);
        check("alt_ptr_in", 32'(bus.ptr_in), 6);
        check("alt_ptr_out", 32'(bus.ptr_out), 6);
        check("alt_empty", 32'(bus.empty), 1);

        // 7 pushes, then asynchronous reset mid-cycle
        bus.push = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        check("pre_rst_count", 32'(bus.count), 7);
        #1 reset = 1'b0;
        #1;
        check("arst_count", 32'(bus.count), 0);
        check("arst_empty", 32'(bus.empty), 1);
        check("arst_aempty", 32'(bus.almost_empty), 1);
        check("arst_full", 32'(bus.full), 0);
        check("arst_ptr_in", 32'(bus.ptr_in), 0);
        check("arst_en_write", 32'(bus.en_write), 0);
        cyc();
        #1 reset = 1'b1;
        #1;
        check("post_rst_ptr_in", 32'(bus.ptr_in), 0);
        check("post_rst_en_write", 32'(bus.en_write), 1);
        cyc();
        check("post_rst_count", 32'(bus.count), 1);
        bus.push = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
